// File: rtl/lsu_mem_stage.sv
// RV32I memory stage: drives the data-memory req/gnt/rvalid port for loads and stores,
// aligns store lanes, extends load data and passes ALU results straight to writeback.
module lsu_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic [4:0]      ex_rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            mem_err,
  output logic [XLEN-1:0] err_addr
);

  // state | meaning
  // IDLE  | ready for a new op; ALU ops and faults complete from here
  // REQ   | request on the port, waiting for dmem_gnt
  // WAIT  | load granted, waiting for dmem_rvalid
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, state_nxt;

  logic            accept;
  logic            is_mem;
  logic            size_ok;
  logic            misalign;
  logic            alu_go;
  logic            bad_go;
  logic            mem_go;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic [2:0]      f3_q;
  logic [1:0]      ofs_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] ld_data;

  assign ex_ready = (state == IDLE);
  assign accept   = ex_valid & ex_ready;
  assign is_mem   = ex_is_load | ex_is_store;

  always_comb begin
    size_ok = 1'b0;
    if (ex_is_load && ex_is_store)
      size_ok = 1'b0;
    else if (ex_is_load)
      size_ok = ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (ex_is_store)
      size_ok = ex_funct3 inside {3'b000, 3'b001, 3'b010};
  end

  assign misalign = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                    ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));

  assign alu_go = accept & ~is_mem;
  assign bad_go = accept & is_mem & (~size_ok | misalign);
  assign mem_go = accept & is_mem & size_ok & ~misalign;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ex_wdata;
    case (ex_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ex_addr[1:0];
        st_wdata = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << ex_addr[1:0];
        st_wdata = {2{ex_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = ex_wdata;
      end
    endcase
  end

  assign lane = dmem_rdata >> {ofs_q, 3'b000};

  always_comb begin
    ld_data = lane;
    case (f3_q)
      3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_data = {24'h0, lane[7:0]};
      3'b101:  ld_data = {16'h0, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_go) state_nxt = REQ;
      // dmem_we still holds the latched op kind while in REQ
      REQ:  if (dmem_gnt) state_nxt = dmem_we ? IDLE : WAIT;
      WAIT: if (dmem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      mem_err    <= 1'b0;
      err_addr   <= '0;
      f3_q       <= '0;
      ofs_q      <= '0;
      rd_q       <= '0;
    end else begin
      wb_valid <= 1'b0;
      mem_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (alu_go && (ex_rd != 5'd0)) begin
            wb_valid <= 1'b1;
            wb_rd    <= ex_rd;
            wb_data  <= ex_addr;
          end
          if (bad_go) begin
            mem_err  <= 1'b1;
            err_addr <= ex_addr;
          end
          if (mem_go) begin
            dmem_req   <= 1'b1;
            dmem_we    <= ex_is_store;
            dmem_addr  <= {ex_addr[XLEN-1:2], 2'b00};
            dmem_be    <= ex_is_store ? st_be : 4'b1111;
            dmem_wdata <= st_wdata;
            f3_q       <= ex_funct3;
            ofs_q      <= ex_addr[1:0];
            rd_q       <= ex_rd;
          end
        end
        REQ: begin
          if (dmem_gnt) dmem_req <= 1'b0;
        end
        WAIT: begin
          if (dmem_rvalid && (rd_q != 5'd0)) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= ld_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
